// File: rtl/cnn_res_pkg.sv
// Shared constants for the CNN result write-back unit: arbitration modes and word byte size.
package cnn_res_pkg;

  localparam logic [1:0] RES_MODE_SINGLE = 2'd0;
  localparam logic [1:0] RES_MODE_ROTATE = 2'd1;
  localparam logic [1:0] RES_MODE_RR     = 2'd2;

  function automatic int BYTES(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/cnn_res_fifo.sv
// Per-channel result FIFO; head/tail pointers carry an extra wrap bit to tell full from empty.
module cnn_res_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wp, rp;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rp[PW-1:0]];
  assign full  = (wp[PW-1:0] == rp[PW-1:0]) && (wp[PW] != rp[PW]);
  assign empty = (wp == rp);

endmodule

// File: rtl/cnn_res_writer.sv
// Result write-back: CH channel FIFOs drained through one registered memory write port.
// Optional ReLU clamp on push selected by CNN_RES_RELU_EN.
module cnn_res_writer
  import cnn_res_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic           cfg_valid,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [CH-1:0]  in_valid,
  input  logic [CH*DW-1:0] in_data,
  output logic           in_stall,
  output logic           wr_valid,
  input  logic           wr_ready,
  output logic [AW-1:0]  wr_addr,
  output logic [DW-1:0]  wr_data,
  output logic [CW-1:0]  wr_ch,
  output logic           empty
);

  logic [CH-1:0] f_full, f_empty, push, pop;
  logic [DW-1:0] f_rdata [CH];
  logic [AW-1:0] addr [CH];
  logic [CW-1:0] p, sel;
  logic          sel_ok, load;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DW-1:0] d;
`ifdef CNN_RES_RELU_EN
    assign d = in_data[i*DW+DW-1] ? '0 : in_data[i*DW +: DW];
`else
    assign d = in_data[i*DW +: DW];
`endif
    // A single full FIFO blocks every channel so the producer can hold its whole vector.
    assign push[i] = in_valid[i] & ~in_stall & ~flush;
    assign pop[i]  = load && (sel == CW'(i));

    cnn_res_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .wdata (d),
      .pop   (pop[i]),
      .rdata (f_rdata[i]),
      .full  (f_full[i]),
      .empty (f_empty[i])
    );
  end

  assign in_stall = |f_full;
  assign empty    = (&f_empty) & ~wr_valid;

  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    case (mode)
      RES_MODE_SINGLE: sel_ok = ~f_empty[0];
      RES_MODE_ROTATE: begin
        sel    = p;
        sel_ok = ~f_empty[p];
      end
      default: begin
        for (int j = 0; j < CH; j++) begin
          if (!sel_ok && !f_empty[(int'(p) + j) % CH]) begin
            sel    = CW'((int'(p) + j) % CH);
            sel_ok = 1'b1;
          end
        end
      end
    endcase
  end

  assign load = (~wr_valid | wr_ready) & sel_ok & ~flush;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_ch    <= '0;
      p        <= '0;
    end else begin
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr[sel];
        wr_data  <= f_rdata[sel];
        wr_ch    <= sel;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
      if (start) p <= '0;
      else if (load && mode != RES_MODE_SINGLE)
        p <= (sel == CW'(CH - 1)) ? '0 : sel + CW'(1);
    end
  end

  // Base addresses survive flush; a same-cycle cfg write overrides the pop increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) addr[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_valid && cfg_ch == CW'(i)) addr[i] <= cfg_addr;
        else if (pop[i])                   addr[i] <= addr[i] + AW'(BYTES(DW));
      end
    end
  end

endmodule

// File: tb/tb_cnn_res_writer.sv
// Self-checking bench for cnn_res_writer: queue-based reference model plus directed literal checks.
module tb_cnn_res_writer;
  localparam int CH = 4, DW = 32, AW = 32, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, start, cfg_valid, wr_ready;
  logic [1:0] mode, cfg_ch, wr_ch;
  logic [31:0] cfg_addr, wr_addr, wr_data;
  logic [3:0] in_valid;
  logic [127:0] in_data;
  logic in_stall, wr_valid, empty;

  cnn_res_writer #(.CH(CH), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .mode(mode),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .in_valid(in_valid), .in_data(in_data), .in_stall(in_stall),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ch(wr_ch), .empty(empty)
  );

  int tests = 0, errors = 0;
  bit en = 0;

  logic [31:0] mq[CH][$];
  logic [31:0] m_addr[CH];
  int m_p, m_wc;
  logic m_v;
  logic [31:0] m_wa, m_wd;

  logic [31:0] lg_addr[$], lg_data[$];
  int lg_ch[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef CNN_RES_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_step();
    int k;
    bit ok, stall;
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin mq[i].delete(); m_addr[i] = 0; end
      m_p = 0; m_v = 0; m_wa = 0; m_wd = 0; m_wc = 0;
    end else if (flush) begin
      for (int i = 0; i < CH; i++) mq[i].delete();
      m_p = 0; m_v = 0; m_wa = 0; m_wd = 0; m_wc = 0;
      if (cfg_valid) m_addr[cfg_ch] = cfg_addr;
    end else begin
      stall = 0;
      for (int i = 0; i < CH; i++) if (mq[i].size() >= DEPTH) stall = 1;
      ok = 0; k = 0;
      if (mode == 0) ok = mq[0].size() > 0;
      else if (mode == 1) begin k = m_p; ok = mq[k].size() > 0; end
      else begin
        for (int j = 0; j < CH; j++)
          if (!ok && mq[(m_p + j) % CH].size() > 0) begin k = (m_p + j) % CH; ok = 1; end
      end
      if (m_v && wr_ready) m_v = 0;
      if (ok && !m_v) begin
        m_v = 1; m_wa = m_addr[k]; m_wd = mq[k].pop_front(); m_wc = k;
        m_addr[k] = m_addr[k] + 32'd4;
        if (mode != 0) m_p = (k + 1) % CH;
      end
      if (!stall)
        for (int i = 0; i < CH; i++) if (in_valid[i]) mq[i].push_back(relu(in_data[i*32 +: 32]));
      if (start) m_p = 0;
      if (cfg_valid) m_addr[cfg_ch] = cfg_addr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    bit m_empty, m_stall;
    @(negedge clk);
    if (en) begin
      m_empty = !m_v; m_stall = 0;
      for (int i = 0; i < CH; i++) begin
        if (mq[i].size() != 0) m_empty = 0;
        if (mq[i].size() >= DEPTH) m_stall = 1;
      end
      check("wr_valid", wr_valid, m_v);
      check("wr_addr", wr_addr, m_wa);
      check("wr_data", wr_data, m_wd);
      check("wr_ch", wr_ch, m_wc);
      check("empty", empty, m_empty);
      check("in_stall", in_stall, m_stall);
      if (rst && wr_valid && wr_ready && !flush) begin
        lg_addr.push_back(wr_addr); lg_data.push_back(wr_data); lg_ch.push_back(int'(wr_ch));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ch(input int ch, input logic [31:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*32 +: 32] = d;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; cfg_valid = 0; start = 0; flush = 0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!(empty === 1'b1) && n < 50) begin tick(); n++; end
    check(name, empty, 1'b1);
    tick();
  endtask

  task automatic clear_log();
    lg_addr.delete(); lg_data.delete(); lg_ch.delete();
  endtask

  initial begin
    rst = 0; mode = 0; wr_ready = 0; cfg_ch = 0; cfg_addr = 0;
    idle_inputs();
    tick();
    en = 1;
    tick(); tick();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_in_stall", in_stall, 1'b0);
    check("rst_wr_addr", wr_addr, 32'h0);
    rst = 1;
    tick();

    // Rotation over four channels, two words each.
    for (int i = 0; i < CH; i++) begin
      cfg_valid = 1; cfg_ch = 2'(i); cfg_addr = 32'h1000 * (i + 1);
      tick();
    end
    cfg_valid = 0;
    mode = 1; start = 1; wr_ready = 1;
    tick();
    start = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < CH; i++) push_ch(i, 32'h100 * (c + 1) + i);
      tick();
    end
    idle_inputs();
    wait_empty("t1_drain");
    check("t1_count", lg_addr.size(), 8);
    for (int i = 0; i < 8 && i < lg_addr.size(); i++) begin
      check("t1_addr", lg_addr[i], 32'h1000 * (i % 4 + 1) + 4 * (i / 4));
      check("t1_data", lg_data[i], 32'h100 * (i / 4 + 1) + i % 4);
    end
    clear_log();

    // Skip-empty round-robin versus strict rotation on sparse input.
    mode = 2; start = 1;
    push_ch(1, 32'hA); push_ch(3, 32'hB);
    tick();
    idle_inputs();
    wait_empty("t2_drain");
    check("t2_count", lg_ch.size(), 2);
    if (lg_ch.size() == 2) begin
      check("t2_ch0", lg_ch[0], 1); check("t2_ch1", lg_ch[1], 3);
      check("t2_d0", lg_data[0], 32'hA); check("t2_d1", lg_data[1], 32'hB);
      check("t2_a0", lg_addr[0], 32'h2008); check("t2_a1", lg_addr[1], 32'h4008);
    end
    clear_log();
    mode = 1; start = 1;
    push_ch(1, 32'hA); push_ch(3, 32'hB);
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    check("t2_rot_count", lg_ch.size(), 0);
    check("t2_rot_valid", wr_valid, 1'b0);
    check("t2_rot_empty", empty, 1'b0);
    flush = 1;
    tick();
    flush = 0;
    check("t2_flush_empty", empty, 1'b1);
    tick();

    // Backpressure: fill FIFO plus output register, then one dropped push.
    mode = 0; wr_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin push_ch(0, 32'h50 + i); tick(); end
    idle_inputs();
    check("t3_stall", in_stall, 1'b1);
    push_ch(0, 32'h99);
    tick();
    idle_inputs();
    wr_ready = 1;
    wait_empty("t3_drain");
    check("t3_count", lg_data.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < lg_data.size(); i++) begin
      check("t3_data", lg_data[i], 32'h50 + i);
      check("t3_addr", lg_addr[i], 32'h1008 + 4 * i);
    end
    clear_log();

    // cfg write colliding with a pop on channel 2.
    mode = 2; start = 1;
    push_ch(2, 32'h21);
    tick();
    idle_inputs();
    push_ch(2, 32'h22); cfg_valid = 1; cfg_ch = 2; cfg_addr = 32'h8000;
    tick();
    idle_inputs();
    wait_empty("t4_drain");
    check("t4_count", lg_addr.size(), 2);
    if (lg_addr.size() == 2) begin
      check("t4_a0", lg_addr[0], 32'h3008);
      check("t4_a1", lg_addr[1], 32'h8000);
      check("t4_d1", lg_data[1], 32'h22);
    end
    clear_log();

    // Flush while a write is pending.
    mode = 0; wr_ready = 0;
    for (int i = 0; i < 3; i++) begin push_ch(0, 32'h61 + i); tick(); end
    idle_inputs();
    check("t5_pending", wr_valid, 1'b1);
    flush = 1;
    tick();
    flush = 0;
    check("t5_valid", wr_valid, 1'b0);
    check("t5_empty", empty, 1'b1);
    wr_ready = 1;
    push_ch(0, 32'h70);
    tick();
    idle_inputs();
    wait_empty("t5_drain");
    check("t5_count", lg_addr.size(), 1);
    if (lg_addr.size() == 1) begin
      check("t5_addr", lg_addr[0], 32'h1020);
      check("t5_data", lg_data[0], 32'h70);
    end
    clear_log();

    // Sign handling on push.
    push_ch(0, 32'hFFFF_FFFF);
    tick();
    push_ch(0, 32'h5);
    tick();
    idle_inputs();
    wait_empty("t6_drain");
    check("t6_count", lg_data.size(), 2);
    if (lg_data.size() == 2) begin
`ifdef CNN_RES_RELU_EN
      check("t6_d0", lg_data[0], 32'h0);
`else
      check("t6_d0", lg_data[0], 32'hFFFF_FFFF);
`endif
      check("t6_d1", lg_data[1], 32'h5);
      check("t6_a1", lg_addr[1], 32'h1028);
    end

    en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/cnn_res_writer.md
# cnn_res_writer

Parametrised result write-back unit for the CNN accelerator. It buffers per-channel convolution/pooling results in CH independent FIFOs and drains them through a registered memory write port. Each channel owns an auto-incrementing destination address. Selectable arbitration is single-channel (pool), strict rotation (conv, legacy order) or skip-empty round-robin (new). It sits between the conv/pool datapath and the accelerator's shared memory request mux.

## Interface
Parameters:
- CH, 4, number of result channels (≥1)
- DW, 32, result word width (multiple of 8)
- AW, 32, address width
- DEPTH, 4, entries per channel FIFO (power of 2, ≥2)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-low
- flush  in  1  clears all FIFOs, output register and channel pointer; base addresses kept
- start  in  1  new operation: channel pointer ← 0
- mode  in  2  0 = channel 0 only, 1 = strict rotation, 2 = skip-empty round-robin; 3 behaves as 2
- cfg_valid  in  1  write a channel base address
- cfg_ch  in  clog2(CH) (min 1)  channel to configure
- cfg_addr  in  AW  base byte address
- in_valid  in  CH  per-channel result push request
- in_data  in  CH*DW  per-channel results, channel i at [i*DW +: DW]
- in_stall  out  1  any FIFO full; producer must hold all pushes
- wr_valid  out  1  write request pending
- wr_ready  in  1  memory accepts request
- wr_addr  out  AW  destination byte address
- wr_data  out  DW  result word
- wr_ch  out  clog2(CH) (min 1)  source channel
- empty  out  1  all FIFOs and output register empty

## Operation
- Push: channel i is written when in_valid[i] & ~in_stall. in_stall = OR of per-FIFO full. While in_stall is high, all pushes are dropped, including pushes to non-full channels.
- FIFO: head/tail pointers plus wrap bits. Full means pointers equal and wrap bits differ. Empty means pointers equal and wrap bits equal.
- Output register loads when it is empty or when wr_valid & wr_ready, provided the selected channel is non-empty.
- Selected channel per mode:
  - 0: always channel 0.
  - 1: pointer p. Wait on channel p until it is non-empty. After popping p, p ← p+1, wrapping CH-1→0.
  - 2: first non-empty channel at or after p in cyclic order. After popping channel k, p ← k+1 mod CH.
- On load: wr_addr ← addr[k], addr[k] ← addr[k] + DW/8 (wraps mod 2^AW), wr_ch ← k, wr_data ← FIFO head, pop k.
- A cfg write and a pop on the same channel in the same cycle: the cfg value wins and the increment is lost.
- A push and a pop on the same channel in the same cycle are both performed. The count is unchanged. A push into a full FIFO is impossible, because in_stall is high.
- mode is only changed while empty=1. The behaviour for a change while non-empty is undefined.

## Timing
- Reset values: in_stall=0, wr_valid=0, wr_addr=0, wr_data=0, wr_ch=0, empty=1. Pointer p=0, all addr[i]=0.
- Push latency: data pushed at edge N is presented on wr_valid after edge N+1 at the earliest.
- Handshake: wr_valid, wr_addr, wr_data and wr_ch stay stable until the cycle wr_valid & wr_ready. A back-to-back load in the handshake cycle gives one word per cycle at full throughput.
- flush or start takes effect at the next edge. flush has priority over start, pushes and loads in the same cycle. Reset has priority over everything.
- flush mid-transaction drops the pending wr_valid without a handshake.
- empty is combinational from the registered state.

## Configuration
- CNN_RES_RELU_EN:
  - Defined: each pushed word is treated as signed DW-bit. A negative word is stored as 0 and a non-negative word is unchanged.
  - Undefined: words are stored unmodified.

## Structure
- Package cnn_res_pkg:
  - mode constants RES_MODE_SINGLE=0, RES_MODE_ROTATE=1, RES_MODE_RR=2
  - helper BYTES(DW) = DW/8
- Sub-module cnn_res_fifo (DW, DEPTH): one per channel, generated CH times. It exposes push, pop, rdata, full and empty.
- Top level holds the address array, arbiter and output register.

## Test plan
- Mode 1, CH=4, bases 0x1000/0x2000/0x3000/0x4000, push one word per channel per cycle for 2 cycles, wr_ready=1 → addresses 0x1000, 0x2000, 0x3000, 0x4000, 0x1004, 0x2004, 0x3004, 0x4004.
- Mode 2: push only channels 1 and 3 (0xA, 0xB), p=0 → wr_ch 1 then 3. Mode 1 with the same stimulus → no output, stalled on channel 0.
- Mode 0, wr_ready=0, push channel 0 for DEPTH+1 cycles → in_stall=1 after DEPTH+1 entries (DEPTH in FIFO + 1 in output register). The extra push is dropped. Release wr_ready → exactly DEPTH+1 words at 4-byte stride.
- cfg_valid to channel 2 (0x8000) in the same cycle as a channel-2 pop → the next channel-2 write goes to 0x8000.
- flush with wr_valid=1 and entries pending → next cycle wr_valid=0, empty=1. Base addresses retain their incremented values.
- With CNN_RES_RELU_EN, push 0xFFFFFFFF and 0x00000005 → wr_data 0x00000000, 0x00000005. Without the macro → 0xFFFFFFFF, 0x00000005.
